// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and default widths for the memory stage
package mem_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] aluOut;
        logic [DEF_DATA_W-1:0] memData;
        logic                  wbSel;
        logic [DEF_REG_AW-1:0] rd;
        logic                  regWrite;
    } wb_bundle_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - variable-latency req/ack data-memory port
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memAck
    );
endinterface

// File: rtl/mem_access_stage_wb_reg.sv
// rtl/mem_access_stage_wb_reg.sv - MEM/WB boundary register with load and bubble control
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       bubble,
    input  wb_bundle_t d,
    output wb_bundle_t q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= bubble ? '0 : d;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: load/store handshake, stall, MEM/WB register
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inValid,
    input  logic                flush,
    input  logic [DATA_W-1:0]   ALUresult,
    input  logic [DATA_W-1:0]   storeData,
    input  logic [REG_AW-1:0]   rdIn,
    input  logic                SIG_MemRead,
    input  logic                SIG_MemWrite,
    input  logic                SIG_WBdataIn,
    input  logic                SIG_RegWriteIn,
    output logic                stallOut,
    mem_access_stage_if.master  mem,
    output logic [DATA_W-1:0]   ALUoutWB,
    output logic [DATA_W-1:0]   readMemoryDataWB,
    output logic                SIG_WBdataWB,
    output logic [REG_AW-1:0]   rdWB,
    output logic                SIG_RegWriteWB,
    output logic                memFault
);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              fault_q, fault_next;
    logic              stall_c;
    logic              latch_en;
    logic              wb_load, wb_bubble;
    wb_bundle_t        wb_d, wb_q;

    logic [DATA_W-1:0] lat_addr, lat_wdata;
    logic [REG_AW-1:0] lat_rd;
    logic              lat_we, lat_wbsel, lat_regwrite;

    logic memop, aligned, issue, misalign, expire;

    assign memop    = inValid & (SIG_MemRead | SIG_MemWrite);
    assign aligned  = (ALUresult[1:0] == 2'b00);
    assign issue    = memop & aligned & ~flush;
    assign misalign = memop & ~aligned & ~flush;
    // cnt holds the number of already-elapsed WAIT cycles without ack
    assign expire   = (ACK_TIMEOUT != 0) && (cnt == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_c    = 1'b0;
        fault_next = 1'b0;
        latch_en   = 1'b0;
        wb_load    = 1'b1;
        wb_bubble  = 1'b1;
        wb_d       = '0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (issue) begin
                    stall_c    = 1'b1;
                    latch_en   = 1'b1;
                    state_next = WAIT;
                end else if (misalign) begin
                    fault_next = 1'b1;
                end else if (inValid && !flush) begin
                    wb_bubble     = 1'b0;
                    wb_d.aluOut   = ALUresult;
                    wb_d.wbSel    = SIG_WBdataIn;
                    wb_d.rd       = rdIn;
                    wb_d.regWrite = SIG_RegWriteIn;
                end
            end
            WAIT: begin
                if (mem.memAck) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    wb_bubble     = 1'b0;
                    wb_d.aluOut   = lat_addr;
                    wb_d.memData  = mem.memRdata;
                    wb_d.wbSel    = lat_wbsel;
                    wb_d.rd       = lat_rd;
                    wb_d.regWrite = lat_regwrite & ~lat_we;
                end else if (expire) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    fault_next = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    wb_load  = 1'b0;
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            fault_q <= fault_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_rd       <= '0;
            lat_we       <= 1'b0;
            lat_wbsel    <= 1'b0;
            lat_regwrite <= 1'b0;
        end else if (latch_en) begin
            lat_addr     <= ALUresult;
            lat_wdata    <= storeData;
            lat_rd       <= rdIn;
            lat_we       <= SIG_MemWrite;
            lat_wbsel    <= SIG_WBdataIn;
            lat_regwrite <= SIG_RegWriteIn;
        end
    end

    mem_wb_reg u_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (wb_load),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    // stall is combinational from the inputs in IDLE, so it is forced low while reset is held
    assign stallOut     = stall_c & rst_n;
    assign mem.memReq   = (state == WAIT);
    assign mem.memWe    = (state == WAIT) & lat_we;
    assign mem.memAddr  = (state == WAIT) ? lat_addr  : '0;
    assign mem.memWdata = (state == WAIT) ? lat_wdata : '0;

    assign ALUoutWB         = wb_q.aluOut;
    assign readMemoryDataWB = wb_q.memData;
    assign SIG_WBdataWB     = wb_q.wbSel;
    assign rdWB             = wb_q.rd;
    assign SIG_RegWriteWB   = wb_q.regWrite;
    assign memFault         = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - vector table and scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, flush, SIG_MemRead, SIG_MemWrite, SIG_WBdataIn, SIG_RegWriteIn;
    logic [31:0] ALUresult, storeData;
    logic [4:0]  rdIn;
    logic        stallOut, SIG_WBdataWB, SIG_RegWriteWB, memFault;
    logic [31:0] ALUoutWB, readMemoryDataWB;
    logic [4:0]  rdWB;

    mem_access_stage_if #(.DATA_W(32)) mem_if ();

    mem_access_stage #(.DATA_W(32), .REG_AW(5), .ACK_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .inValid          (inValid),
        .flush            (flush),
        .ALUresult        (ALUresult),
        .storeData        (storeData),
        .rdIn             (rdIn),
        .SIG_MemRead      (SIG_MemRead),
        .SIG_MemWrite     (SIG_MemWrite),
        .SIG_WBdataIn     (SIG_WBdataIn),
        .SIG_RegWriteIn   (SIG_RegWriteIn),
        .stallOut         (stallOut),
        .mem              (mem_if),
        .ALUoutWB         (ALUoutWB),
        .readMemoryDataWB (readMemoryDataWB),
        .SIG_WBdataWB     (SIG_WBdataWB),
        .rdWB             (rdWB),
        .SIG_RegWriteWB   (SIG_RegWriteWB),
        .memFault         (memFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, flsh, rd_en, wr_en, wbsel, regw;
        logic [31:0] alu, sdata, rdata;
        logic [4:0]  rd;
        int          ack_after;
        int          exp_req, exp_stall;
        logic        exp_we, exp_fault;
        logic [31:0] e_alu, e_md;
        logic        e_sel;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic valid, flsh, rd_en, wr_en, wbsel, regw,
                                input logic [31:0] alu, sdata, input logic [4:0] rd,
                                input logic [31:0] rdata, input int ack_after,
                                input int exp_req, exp_stall, input logic exp_we, exp_fault,
                                input logic [31:0] e_alu, e_md, input logic e_sel,
                                input logic [4:0] e_rd, input logic e_rw);
        vec_t v;
        v.valid = valid; v.flsh = flsh; v.rd_en = rd_en; v.wr_en = wr_en;
        v.wbsel = wbsel; v.regw = regw; v.alu = alu; v.sdata = sdata; v.rd = rd;
        v.rdata = rdata; v.ack_after = ack_after; v.exp_req = exp_req;
        v.exp_stall = exp_stall; v.exp_we = exp_we; v.exp_fault = exp_fault;
        v.e_alu = e_alu; v.e_md = e_md; v.e_sel = e_sel; v.e_rd = e_rd; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inValid = 0; flush = 0; SIG_MemRead = 0; SIG_MemWrite = 0;
        SIG_WBdataIn = 0; SIG_RegWriteIn = 0; ALUresult = 0; storeData = 0; rdIn = 0;
    endtask

    task automatic drive(input vec_t v);
        inValid = v.valid; flush = v.flsh; SIG_MemRead = v.rd_en; SIG_MemWrite = v.wr_en;
        SIG_WBdataIn = v.wbsel; SIG_RegWriteIn = v.regw; ALUresult = v.alu;
        storeData = v.sdata; rdIn = v.rd;
    endtask

    // called at a negedge; returns at the negedge after the instruction retires
    task automatic apply(input int idx, input vec_t v);
        int   req_n, stall_n;
        bit   bus_ok, done;
        vec_t e;
        exp_q.push_back(v);
        drive(v);
        req_n = 0; stall_n = 0; bus_ok = 1; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) check($sformatf("v%0d_req_idle", idx), mem_if.memReq, 0);
            if (mem_if.memReq) begin
                req_n++;
                mem_if.memAck   = (req_n == v.ack_after);
                mem_if.memRdata = v.rdata;
                if (mem_if.memAddr !== v.alu || mem_if.memWe !== v.exp_we ||
                    (v.exp_we && mem_if.memWdata !== v.sdata))
                    bus_ok = 0;
            end else begin
                mem_if.memAck = 0;
            end
            #1;
            if (stallOut) stall_n++;
            else done = 1;
            @(posedge clk);
        end
        if (!done) check($sformatf("v%0d_retire_bound", idx), 0, 1);
        @(negedge clk);
        mem_if.memAck = 0;
        e = exp_q.pop_front();
        check($sformatf("v%0d_alu_wb", idx),   ALUoutWB,         e.e_alu);
        check($sformatf("v%0d_mdata_wb", idx), readMemoryDataWB, e.e_md);
        check($sformatf("v%0d_wbsel_wb", idx), SIG_WBdataWB,     e.e_sel);
        check($sformatf("v%0d_rd_wb", idx),    rdWB,             e.e_rd);
        check($sformatf("v%0d_regw_wb", idx),  SIG_RegWriteWB,   e.e_rw);
        check($sformatf("v%0d_fault", idx),    memFault,         e.exp_fault);
        check($sformatf("v%0d_req_cycles", idx),   req_n,   e.exp_req);
        check($sformatf("v%0d_stall_cycles", idx), stall_n, e.exp_stall);
        check($sformatf("v%0d_bus", idx),          bus_ok,  1);
        idle_inputs();
    endtask

    function automatic logic any_out();
        return |{stallOut, mem_if.memReq, mem_if.memWe, mem_if.memAddr, mem_if.memWdata,
                 ALUoutWB, readMemoryDataWB, SIG_WBdataWB, rdWB, SIG_RegWriteWB, memFault};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //              vld fl rd wr sel rw alu           sdata         rd  rdata         ack req st we flt e_alu         e_md          sel rd  rw
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 32'h1234,     32'h0,        5,  32'h0,        0,  0,  0, 0, 0, 32'h1234,     32'h0,        0, 5,  1);
        vecs[1]  = mk(1, 0, 1, 0, 1, 1, 32'h100,      32'h0,        7,  32'hDEADBEEF, 3,  3,  3, 0, 0, 32'h100,      32'hDEADBEEF, 1, 7,  1);
        vecs[2]  = mk(1, 0, 0, 1, 0, 1, 32'h200,      32'hA5A5A5A5, 9,  32'h11111111, 1,  1,  1, 1, 0, 32'h200,      32'h11111111, 0, 9,  0);
        vecs[3]  = mk(1, 0, 1, 0, 1, 1, 32'h102,      32'h0,        3,  32'h55,       1,  0,  0, 0, 1, 32'h0,        32'h0,        0, 0,  0);
        vecs[4]  = mk(1, 0, 1, 0, 1, 1, 32'h300,      32'h0,        4,  32'h77,       0,  4,  4, 0, 1, 32'h0,        32'h0,        0, 0,  0);
        vecs[5]  = mk(1, 0, 1, 0, 1, 1, 32'h304,      32'h0,        6,  32'hCAFEF00D, 4,  4,  4, 0, 0, 32'h304,      32'hCAFEF00D, 1, 6,  1);
        vecs[6]  = mk(1, 1, 1, 0, 1, 1, 32'h400,      32'h0,        2,  32'h99,       1,  0,  0, 0, 0, 32'h0,        32'h0,        0, 0,  0);
        vecs[7]  = mk(0, 0, 1, 0, 1, 1, 32'h404,      32'h0,        2,  32'h99,       1,  0,  0, 0, 0, 32'h0,        32'h0,        0, 0,  0);
        vecs[8]  = mk(1, 0, 1, 1, 1, 1, 32'h500,      32'h12345678, 8,  32'h0BADF00D, 2,  2,  2, 1, 0, 32'h500,      32'h0BADF00D, 1, 8,  0);
        vecs[9]  = mk(1, 0, 0, 1, 0, 0, 32'h203,      32'h1,        1,  32'h0,        1,  0,  0, 0, 1, 32'h0,        32'h0,        0, 0,  0);
        vecs[10] = mk(1, 1, 0, 0, 0, 1, 32'h55,       32'h0,        10, 32'h0,        0,  0,  0, 0, 0, 32'h0,        32'h0,        0, 0,  0);
        vecs[11] = mk(1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        31, 32'h0,        0,  0,  0, 0, 0, 32'hFFFFFFFF, 32'h0,        1, 31, 0);

        rst_n = 0;
        idle_inputs();
        mem_if.memAck = 0;
        mem_if.memRdata = 0;
        #1;
        check("reset_outputs", any_out(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_reset_outputs", any_out(), 0);

        for (int i = 0; i < 12; i++) apply(i, vecs[i]);

        // memFault must be a single-cycle pulse
        apply(3, vecs[3]);
        @(negedge clk);
        check("fault_pulse_width", memFault, 0);

        // reset asserted mid-access discards it and clears every output at once
        drive(vecs[1]);
        @(posedge clk);
        @(negedge clk);
        check("wait_req_before_reset", mem_if.memReq, 1);
        #2 rst_n = 0;
        #1;
        check("reset_mid_wait_req", mem_if.memReq, 0);
        check("reset_mid_wait_outputs", any_out(), 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        apply(1, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
